// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store unit and the data-memory responder.
//   req_valid/req_ready : request handshake, transfer when both are high
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I load/store funct3
//   req_addr            : byte address
//   req_wdata           : right-justified store data
//   rsp_valid           : one-cycle response pulse (always accepted)
//   rsp_rdata           : extended load data, 0 for stores and faults
//   rsp_err             : access faulted, qualified by rsp_valid
// Modports: master = load/store unit side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs lane-masked byte/half/word
// stores, returns sign/zero-extended load data after WAIT_CYCLES wait states.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : dmem_responder_if.slave (request handshake + one-cycle response)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, word index = req_addr[31:2]
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
// Build option:
//   DMEM_ERR_EN : when defined, misaligned / illegal-funct3 / out-of-range accesses fault
//                 (rsp_err=1, rdata=0, no write). When undefined, rsp_err is 0, misaligned
//                 addresses are aligned down, illegal funct3 acts as LW/SW and the word index
//                 wraps modulo DEPTH_WORDS.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic            accept;
  logic            op_we;
  logic [2:0]      op_f3;
  logic [31:0]     op_addr, op_wdata;
  logic            op_legal;
  logic [1:0]      size;
  logic [1:0]      off;
  logic [IdxW-1:0] idx;
  logic            acc_err;
  logic [31:0]     word_rd, wr_rep, wr_word, shifted, ld_data;
  logic [3:0]      lane_mask;
  logic            commit;
  logic            mem_we;
`ifdef DMEM_ERR_EN
  logic            misaligned;
  logic            in_range;
`endif

  // In IDLE the access may complete on the accepting edge (WAIT_CYCLES==0), so the live
  // request fields are used there; otherwise the latched copy.
  always_comb begin
    accept = (state_q == StIdle) && bus.req_valid && !rst;
    if (state_q == StIdle) begin
      op_we    = bus.req_we;
      op_f3    = bus.req_funct3;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = we_q;
      op_f3    = f3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  // Access decode: size, byte offset, word index and fault.
  always_comb begin
    op_legal = op_we ? (!op_f3[2] && (op_f3[1:0] != 2'b11))
                     : !((op_f3 == 3'b011) || (op_f3[2:1] == 2'b11));
    size = op_f3[1:0];
    off  = op_addr[1:0];
`ifdef DMEM_ERR_EN
    misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    in_range   = {2'b00, op_addr[31:2]} < DEPTH_WORDS;
    acc_err    = !op_legal || misaligned || !in_range;
    idx        = op_addr[IdxW+1:2];
`else
    if (!op_legal) size = 2'b10;
    if (size == 2'b01) off[0] = 1'b0;
    if (size[1]) off = 2'b00;
    idx     = IdxW'(op_addr[31:2] % 30'(DEPTH_WORDS));
    acc_err = 1'b0;
`endif
  end

  // Lane selection for store merge and load extraction.
  always_comb begin
    word_rd   = mem_q[idx];
    lane_mask = 4'b1111;
    wr_rep    = op_wdata;
    case (size)
      2'b00: begin
        lane_mask = 4'b0001 << off;
        wr_rep    = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << off;
        wr_rep    = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
    wr_word = word_rd;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
    end
    shifted = word_rd >> {off, 3'b000};
    ld_data = shifted;
    case (size)
      2'b00:   ld_data = op_f3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = op_f3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Stores commit and loads sample the array on the edge entering RESP.
    if ((state_d == StResp) && (state_q != StResp)) begin
      commit  = 1'b1;
      rdata_d = (op_we || acc_err) ? 32'h0 : ld_data;
      err_d   = acc_err;
    end
    mem_we = commit && op_we && !acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
  assign bus.rsp_err   = (state_q == StResp) && err_q;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int unsigned Depth    = 64;
  localparam int unsigned WaitMain = 3;
`ifdef DMEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if m_bus ();
  dmem_responder_if f_bus ();

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(WaitMain)) u_main (
    .clk(clk), .rst(rst), .bus(m_bus)
  );
  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst), .bus(f_bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model_mem [Depth];

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-level memory, access rules applied with plain arithmetic.
  function automatic void model_access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                       input bit [31:0] wd, output bit [31:0] rd,
                                       output bit er);
    int unsigned idx, off, nbytes;
    bit legal;
    bit [31:0] val;
    idx   = addr >> 2;
    off   = addr % 4;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
    case (f3[1:0])
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      default: nbytes = 4;
    endcase
    rd = 32'h0;
    er = 1'b0;
    if (ErrEn) begin
      if (!legal || (off % nbytes) != 0 || idx >= Depth) begin
        er = 1'b1;
        return;
      end
    end else begin
      if (!legal) nbytes = 4;
      off = off - (off % nbytes);
      idx = idx % Depth;
    end
    if (we) begin
      for (int b = 0; b < nbytes; b++) model_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
    end else begin
      val = 32'h0;
      for (int b = 0; b < nbytes; b++) val[8*b +: 8] = model_mem[idx][8*(off+b) +: 8];
      if (!f3[2] && nbytes < 4 && val[8*nbytes-1])
        for (int b = nbytes; b < 4; b++) val[8*b +: 8] = 8'hFF;
      rd = val;
    end
  endfunction

  function automatic void add_vec(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wd, input bit [31:0] er_d, input bit er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.exp_rdata = er_d; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  // One request on the main DUT; starts and ends just after a posedge.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        output bit [31:0] rd, output bit er);
    bit acc = 1'b0;
    bit got = 1'b0;
    int lat = 0;
    rd = 32'h0;
    er = 1'b0;
    m_bus.req_valid  = 1'b1;
    m_bus.req_we     = we;
    m_bus.req_funct3 = f3;
    m_bus.req_addr   = a;
    m_bus.req_wdata  = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_bus.req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      check("accept_timeout", 32'(acc), 32'd1);
      m_bus.req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    m_bus.req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_bus.rsp_valid) begin
        lat = i;
        got = 1'b1;
        rd  = m_bus.rsp_rdata;
        er  = m_bus.rsp_err;
        break;
      end
    end
    check("rsp_latency", 32'(lat), 32'(WaitMain + 1));
    if (got) begin
      @(negedge clk);
      check("rsp_single_pulse", 32'(m_bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] rd, exp_rd;
    bit        er, exp_er;
    bit        acc;
    bit        exp_rdy [11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit        exp_rsp [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    rst = 1'b1;
    m_bus.req_valid = 1'b0; m_bus.req_we = 1'b0; m_bus.req_funct3 = 3'd0;
    m_bus.req_addr = 32'h0; m_bus.req_wdata = 32'h0;
    f_bus.req_valid = 1'b0; f_bus.req_we = 1'b0; f_bus.req_funct3 = 3'd0;
    f_bus.req_addr = 32'h0; f_bus.req_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(m_bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(m_bus.rsp_valid), 32'd0);
    check("rst_rdata", m_bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(m_bus.rsp_err), 32'd0);
    check("rst_fast_ready", 32'(f_bus.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(m_bus.req_ready), 32'd1);
    check("idle_fast_ready", 32'(f_bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Fill the array so every word is known to the model
    for (int i = 0; i < int'(Depth); i++) begin
      bit [31:0] v = $urandom;
      do_req(1'b1, 3'b010, 32'(i * 4), v, rd, er);
      model_access(1'b1, 3'b010, 32'(i * 4), v, exp_rd, exp_er);
      check("fill_rdata", rd, exp_rd);
      check("fill_err", 32'(er), 32'(exp_er));
    end

    // Reset pulse in the middle of a store's wait states drops it
    m_bus.req_valid = 1'b1; m_bus.req_we = 1'b1; m_bus.req_funct3 = 3'b010;
    m_bus.req_addr = 32'h10; m_bus.req_wdata = 32'hDEADBEEF;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_bus.req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check("t1_accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    m_bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_ready_in_rst", 32'(m_bus.req_ready), 32'd0);
    check("t1_rsp_in_rst", 32'(m_bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_no_rsp", 32'(m_bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    model_access(1'b0, 3'b010, 32'h10, 32'h0, exp_rd, exp_er);
    check("t1_lw_old", rd, exp_rd);
    check("t1_lw_err", 32'(er), 32'd0);

    // Directed vectors
    add_vec(1, 3'b010, 32'h20, 32'h8081F2F3, 32'h0, 0);
    add_vec(0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFF2, 0);
    add_vec(0, 3'b100, 32'h21, 32'h0, 32'h000000F2, 0);
    add_vec(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8081, 0);
    add_vec(0, 3'b101, 32'h22, 32'h0, 32'h00008081, 0);
    add_vec(1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0);
    add_vec(1, 3'b000, 32'h33, 32'h00000055, 32'h0, 0);
    add_vec(0, 3'b010, 32'h30, 32'h0, 32'h55223344, 0);
    add_vec(1, 3'b001, 32'h30, 32'h0000AAAA, 32'h0, 0);
    add_vec(0, 3'b010, 32'h30, 32'h0, 32'h5522AAAA, 0);
    add_vec(1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0);
    add_vec(0, 3'b001, 32'h41, 32'h0, ErrEn ? 32'h0 : 32'hFFFFF00D, ErrEn);
    add_vec(0, 3'b010, 32'h42, 32'h0, ErrEn ? 32'h0 : 32'hCAFEF00D, ErrEn);
    add_vec(1, 3'b010, 32'h00, 32'h01020304, 32'h0, 0);
    add_vec(1, 3'b010, 32'(Depth * 4), 32'hBADC0DE5, 32'h0, ErrEn);
    add_vec(0, 3'b010, 32'h00, 32'h0, ErrEn ? 32'h01020304 : 32'hBADC0DE5, 0);
    add_vec(0, 3'b010, 32'h20, 32'h0, 32'h8081F2F3, 0);
    add_vec(0, 3'b011, 32'h40, 32'h0, ErrEn ? 32'h0 : 32'hCAFEF00D, ErrEn);
    add_vec(1, 3'b101, 32'h40, 32'h00000099, 32'h0, ErrEn);
    add_vec(0, 3'b010, 32'h40, 32'h0, ErrEn ? 32'hCAFEF00D : 32'h00000099, 0);
    add_vec(1, 3'b000, 32'hFF, 32'h00000080, 32'h0, 0);
    add_vec(0, 3'b000, 32'hFF, 32'h0, 32'hFFFFFF80, 0);
    add_vec(0, 3'b101, 32'hFE, 32'h0, {16'h0, 8'h80, model_mem[63][23:16]}, 0);
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
      model_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Held req_valid on the main DUT: ready low through WAIT and RESP, re-accept after RESP
    model_access(1'b0, 3'b010, 32'h20, 32'h0, exp_rd, exp_er);
    m_bus.req_valid = 1'b1; m_bus.req_we = 1'b0; m_bus.req_funct3 = 3'b010;
    m_bus.req_addr = 32'h20; m_bus.req_wdata = 32'h0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check($sformatf("held_ready_c%0d", k), 32'(m_bus.req_ready), 32'(exp_rdy[k]));
      check($sformatf("held_rsp_c%0d", k), 32'(m_bus.rsp_valid), 32'(exp_rsp[k]));
      if (exp_rsp[k]) check($sformatf("held_rdata_c%0d", k), m_bus.rsp_rdata, exp_rd);
      if (k == 9) m_bus.req_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Zero wait states: response on the cycle right after acceptance
    f_bus.req_valid = 1'b1; f_bus.req_we = 1'b1; f_bus.req_funct3 = 3'b010;
    f_bus.req_addr = 32'h8; f_bus.req_wdata = 32'h12345678;
    @(negedge clk);
    check("fast_ready_c0", 32'(f_bus.req_ready), 32'd1);
    @(posedge clk); #1;
    f_bus.req_we = 1'b0;
    @(negedge clk);
    check("fast_rsp_c1", 32'(f_bus.rsp_valid), 32'd1);
    check("fast_ready_c1", 32'(f_bus.req_ready), 32'd0);
    check("fast_sw_rdata", f_bus.rsp_rdata, 32'h0);
    @(negedge clk);
    check("fast_rsp_c2", 32'(f_bus.rsp_valid), 32'd0);
    check("fast_ready_c2", 32'(f_bus.req_ready), 32'd1);
    @(negedge clk);
    check("fast_rsp_c3", 32'(f_bus.rsp_valid), 32'd1);
    check("fast_lw_rdata", f_bus.rsp_rdata, 32'h12345678);
    f_bus.req_valid = 1'b0;
    @(negedge clk);
    check("fast_rsp_c4", 32'(f_bus.rsp_valid), 32'd0);
    check("fast_ready_c4", 32'(f_bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      bit        we = 1'($urandom_range(0, 1));
      bit [2:0]  f3 = 3'($urandom_range(0, 7));
      bit [31:0] a  = 32'($urandom_range(0, int'(Depth) + 7) * 4 + $urandom_range(0, 3));
      bit [31:0] wd = $urandom;
      do_req(we, f3, a, wd, rd, er);
      model_access(we, f3, a, wd, exp_rd, exp_er);
      check($sformatf("rand%0d_rdata we=%0d f3=%0d a=%h", n, we, f3, a), rd, exp_rd);
      check($sformatf("rand%0d_err we=%0d f3=%0d a=%h", n, we, f3, a), 32'(er), 32'(exp_er));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
